// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//
// Accepts one operation at a time and registers the result and an 8-bit flag
// vector. The result is held until the consumer takes it. MUL is a shift-add
// engine that handles one multiplier bit per cycle. Every other operation
// completes in one cycle.
//
// Parameters:
//   WIDTH      datapath width (even, power of two, >= 4)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation request
//   in_ready   request can be accepted (high only in IDLE)
//   op         4-bit operation code
//   a, b       operands, captured at acceptance
//   out_valid  z/flags hold a completed result
//   out_ready  consumer takes the result
//   z          result
//   flags      {EQ, LT, ROT_ERR, MUL_ERR, N, Z, C, V}
//
// Optional feature (macro ALU_SEQ_CARRY_CHAIN_EN):
//   Adds a stored-carry register and the ADC (1100) and SBB (1101) ops. When
//   the macro is undefined, those codes are illegal.
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic [7:0]       flags
);

   localparam int HALF  = WIDTH / 2;
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_ROTL = 4'b0010;
   localparam logic [3:0] OP_ROTR = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
   localparam logic [3:0] OP_ADC  = 4'b1100;
   localparam logic [3:0] OP_SBB  = 4'b1101;
`endif

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, z_q, z_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         flags_q, flags_d;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
   logic               carry_q, carry_d;
`endif

   // Single-cycle datapath, evaluated on the live inputs. Its result is only
   // used in IDLE, where it is registered at acceptance.
   logic [WIDTH:0]     sum;
   logic [SH_W:0]      rot_sh;
   logic [2*WIDTH-1:0] rot_dbl;
   logic [WIDTH-1:0]   alu_z;
   logic               alu_c, alu_v, alu_legal, alu_rot_err, alu_mul_err;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case statement leaves a value unassigned and infers a latch.
      sum         = '0;
      alu_z       = '0;
      alu_c       = 1'b0;
      alu_v       = 1'b0;
      alu_legal   = 1'b1;
      alu_rot_err = (b[WIDTH-1:SH_W] != '0);
      alu_mul_err = (a[WIDTH-1:HALF] != '0) || (b[WIDTH-1:HALF] != '0);
      rot_dbl     = {a, a};
      rot_sh      = '0;
      unique case (op)
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            alu_z = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // The extra top bit of the widened difference is the unsigned borrow.
            sum   = {1'b0, a} - {1'b0, b};
            alu_z = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
`ifdef ALU_SEQ_CARRY_CHAIN_EN
         OP_ADC: begin
            sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
            alu_z = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SBB: begin
            sum   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_q};
            alu_z = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
`endif
         OP_ROTL: begin
            // Shifting {a,a} right by WIDTH-amt leaves a rotated left by amt in
            // the low half; amt=0 shifts by WIDTH and returns a unchanged.
            rot_sh = (SH_W+1)'(WIDTH) - {1'b0, b[SH_W-1:0]};
            if (!alu_rot_err) alu_z = WIDTH'(rot_dbl >> rot_sh);
         end
         OP_ROTR: begin
            rot_sh = {1'b0, b[SH_W-1:0]};
            if (!alu_rot_err) alu_z = WIDTH'(rot_dbl >> rot_sh);
         end
         OP_MUL: ;  // legal products come from the shift-add engine
         OP_AND: alu_z = a & b;
         OP_OR:  alu_z = a | b;
         OP_XOR: alu_z = a ^ b;
         OP_NOT: alu_z = ~a;
         default: alu_legal = 1'b0;
      endcase
   end

   // FSM next-state and register updates.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      flags_d = flags_q;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      carry_d = carry_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (op == OP_MUL && !alu_mul_err) begin
                  state_d = S_MUL;
                  a_d     = a;
                  b_d     = b;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DONE;
                  if (alu_legal) begin
                     z_d     = alu_z;
                     flags_d = {a == b, a < b,
                                alu_rot_err && (op == OP_ROTL || op == OP_ROTR),
                                alu_mul_err && (op == OP_MUL),
                                alu_z[WIDTH-1], alu_z == '0, alu_c, alu_v};
                  end else begin
                     z_d     = '0;
                     flags_d = 8'h04;
                  end
`ifdef ALU_SEQ_CARRY_CHAIN_EN
                  if (op == OP_ADD || op == OP_SUB || op == OP_ADC || op == OP_SBB)
                     carry_d = alu_c;
`endif
               end
            end
         end
         S_MUL: begin
            if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HALF - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
               z_d     = acc_d;
               flags_d = {a_q == b_q, a_q < b_q, 2'b00,
                          acc_d[WIDTH-1], acc_d == '0, 2'b00};
            end
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         flags_q <= '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         flags_q <= flags_d;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign z         = z_q;
   assign flags     = flags_q;

endmodule
